// File: rtl/debug_host.sv
// ============================================================================
// Module   : debug_host
// Purpose  : Host side of the debug link. Sends a one-byte command via UART TX
//            and packs the returned UART RX bytes LSB-first into one frame.
//            Optional inter-byte timeout: define DEBUG_HOST_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module debug_host #(
  parameter int NUM_BYTES   = 40,
  parameter int FRAME_W     = 320,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  input  logic [7:0]         cmd_byte,
  output logic               cmd_ready,
  output logic [7:0]         tx_dato_in,
  output logic               tx_start,
  input  logic               tx_done,
  input  logic [7:0]         rx_dato_out,
  input  logic               rx_done,
  output logic [FRAME_W-1:0] frame_out,
  output logic               frame_valid,
  output logic               busy,
  output logic               error
);

  localparam int c_IDX_W = $clog2(NUM_BYTES + 1);
  localparam logic [c_IDX_W-1:0] c_CNT_FRAME = c_IDX_W'(NUM_BYTES);
  localparam logic [c_IDX_W-1:0] c_CNT_ACK   = c_IDX_W'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEND    = 3'd1,
    S_WAIT_TX = 3'd2,
    S_RECV    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  if ((FRAME_W != NUM_BYTES * 8) || (TIMEOUT_CYC < 1)) begin : g_cfg_check
    $error("debug_host: FRAME_W must equal NUM_BYTES*8 and TIMEOUT_CYC must be >= 1");
  end

  state_t               r_state;
  state_t               w_state_next;
  logic [7:0]           r_cmd;
  logic [c_IDX_W-1:0]   r_expected;
  logic [c_IDX_W-1:0]   r_idx;
  logic [FRAME_W-1:0]   r_frame;
  logic                 r_error;

  logic                 w_is_frame_cmd;
  logic                 w_is_ack_cmd;
  logic                 w_accept;
  logic                 w_reject;
  logic                 w_collect;
  logic                 w_wr;
  logic [c_IDX_W-1:0]   w_idx_inc;
  logic                 w_tmo_hit;

  assign w_is_frame_cmd = (cmd_byte == 8'h63) || (cmd_byte == 8'h73);
  assign w_is_ack_cmd   = (cmd_byte == 8'h61);
  assign w_accept       = (r_state == S_IDLE) && cmd_valid && (w_is_frame_cmd || w_is_ack_cmd);
  assign w_reject       = (r_state == S_IDLE) && cmd_valid && !(w_is_frame_cmd || w_is_ack_cmd);

  // Bytes are already captured in WAIT_TX: the far end may answer before tx_done.
  assign w_collect = (r_state == S_WAIT_TX) || (r_state == S_RECV);
  assign w_wr      = w_collect && rx_done && (r_idx < r_expected);
  assign w_idx_inc = r_idx + c_IDX_W'(1);

`ifdef DEBUG_HOST_TIMEOUT_EN
  localparam int c_TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [c_TMO_W-1:0] r_tmo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo <= '0;
    end else if (!w_collect || rx_done) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + c_TMO_W'(1);
    end
  end

  assign w_tmo_hit = w_collect && !rx_done && (r_tmo == c_TMO_W'(TIMEOUT_CYC - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_next = S_SEND;
      S_SEND:    w_state_next = S_WAIT_TX;
      S_WAIT_TX: begin
        if (w_tmo_hit)    w_state_next = S_IDLE;
        else if (tx_done) w_state_next = S_RECV;
      end
      S_RECV: begin
        // Second term covers a response that completed entirely inside WAIT_TX.
        if (w_tmo_hit)
          w_state_next = S_IDLE;
        else if ((w_wr && (w_idx_inc == r_expected)) || (r_idx >= r_expected))
          w_state_next = S_DONE;
      end
      S_DONE:    w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cmd      <= '0;
      r_expected <= '0;
      r_idx      <= '0;
      r_frame    <= '0;
      r_error    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_error <= w_reject || w_tmo_hit;
      if (w_accept) begin
        r_cmd      <= cmd_byte;
        r_expected <= w_is_frame_cmd ? c_CNT_FRAME : c_CNT_ACK;
        r_idx      <= '0;
        r_frame    <= '0;
      end else if (w_wr) begin
        r_idx <= w_idx_inc;
        for (int b = 0; b < NUM_BYTES; b++) begin
          if (r_idx == c_IDX_W'(b)) r_frame[b*8 +: 8] <= rx_dato_out;
        end
      end
    end
  end

  assign cmd_ready   = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign tx_start    = (r_state == S_SEND);
  assign frame_valid = (r_state == S_DONE);
  assign tx_dato_in  = r_cmd;
  assign frame_out   = r_frame;
  assign error       = r_error;

endmodule

`default_nettype wire

// File: tb/tb_debug_host.sv
// ============================================================================
// Module   : tb_debug_host
// Purpose  : Directed self-checking bench for debug_host.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debug_host;

  localparam int c_NUM_BYTES = 40;
  localparam int c_FRAME_W   = 320;
`ifdef DEBUG_HOST_TIMEOUT_EN
  localparam int c_TMO = 100;
`else
  localparam int c_TMO = 1000000;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 cmd_valid;
  logic [7:0]           cmd_byte;
  logic                 cmd_ready;
  logic [7:0]           tx_dato_in;
  logic                 tx_start;
  logic                 tx_done;
  logic [7:0]           rx_dato_out;
  logic                 rx_done;
  logic [c_FRAME_W-1:0] frame_out;
  logic                 frame_valid;
  logic                 busy;
  logic                 error;

  int n_tot = 0;
  int n_bad = 0;
  int n_txs = 0;
  int n_fv  = 0;
  int n_err = 0;

  logic [c_FRAME_W-1:0] r_exp;
  int base_tx, base_fv;

  debug_host #(
    .NUM_BYTES   (c_NUM_BYTES),
    .FRAME_W     (c_FRAME_W),
    .TIMEOUT_CYC (c_TMO)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_byte    (cmd_byte),
    .cmd_ready   (cmd_ready),
    .tx_dato_in  (tx_dato_in),
    .tx_start    (tx_start),
    .tx_done     (tx_done),
    .rx_dato_out (rx_dato_out),
    .rx_done     (rx_done),
    .frame_out   (frame_out),
    .frame_valid (frame_valid),
    .busy        (busy),
    .error       (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tx_start)    n_txs++;
    if (frame_valid) n_fv++;
    if (error)       n_err++;
  end

  task automatic chk(input string tag, input logic [c_FRAME_W-1:0] got,
                     input logic [c_FRAME_W-1:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] c);
    cmd_valid = 1'b1;
    cmd_byte  = c;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_dato_out = b;
    rx_done     = 1'b1;
    tick();
    rx_done     = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_byte = '0;
    tx_done = 1'b0; rx_dato_out = '0; rx_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_frame", frame_out, 0);
    chk("rst_outs", {tx_start, frame_valid, error, tx_dato_in}, 0);
    rst_n = 1'b1;
    tick();

    // "s": 40 bytes 0x01..0x28
    base_tx = n_txs; base_fv = n_fv;
    issue(8'h73);
    chk("s_txstart", tx_start, 1);
    chk("s_txbyte", tx_dato_in, 8'h73);
    chk("s_busy", {busy, cmd_ready}, 2'b10);
    tick();
    chk("s_txstart_off", tx_start, 0);
    pulse_tx_done();
    r_exp = '0;
    for (int i = 1; i <= 40; i++) begin
      r_exp[(i-1)*8 +: 8] = 8'(i);
      send_byte(8'(i));
      if (i == 39) chk("s_fv_early", frame_valid, 0);
    end
    chk("s_fv", frame_valid, 1);
    chk("s_lo", frame_out[7:0], 8'h01);
    chk("s_hi", frame_out[319:312], 8'h28);
    chk("s_frame", frame_out, r_exp);
    tick();
    chk("s_fv_off", frame_valid, 0);
    chk("s_ready", cmd_ready, 1);
    chk("s_ntx", n_txs - base_tx, 1);
    chk("s_nfv", n_fv - base_fv, 1);

    // "a": single byte "p"
    base_fv = n_fv;
    issue(8'h61);
    tick();
    pulse_tx_done();
    send_byte(8'h70);
    chk("a_fv", frame_valid, 1);
    chk("a_frame", frame_out, 320'h70);
    tick();
    chk("a_ready", cmd_ready, 1);
    chk("a_nfv", n_fv - base_fv, 1);
    send_byte(8'h55);
    chk("idle_rx_ignored", {busy, frame_out}, {1'b0, 320'h70});

    // "x" rejected
    base_tx = n_txs;
    issue(8'h78);
    chk("x_err", error, 1);
    chk("x_idle", {cmd_ready, busy}, 2'b10);
    tick();
    chk("x_err_off", error, 0);
    chk("x_ntx", n_txs - base_tx, 0);

    // "c" with a second command during RECV, extra byte in DONE
    base_tx = n_txs; base_fv = n_fv;
    issue(8'h63);
    tick();
    pulse_tx_done();
    r_exp = '0;
    for (int i = 0; i < 40; i++) begin
      r_exp[i*8 +: 8] = 8'(i * 3 + 7);
      if (i == 2) begin cmd_valid = 1'b1; cmd_byte = 8'h73; end
      send_byte(8'(i * 3 + 7));
      cmd_valid = 1'b0;
    end
    chk("c_fv", frame_valid, 1);
    chk("c_frame", frame_out, r_exp);
    chk("c_txbyte", tx_dato_in, 8'h63);
    send_byte(8'hFF);
    chk("c_extra_ignored", frame_out, r_exp);
    tick();
    chk("c_ntx", n_txs - base_tx, 1);
    chk("c_nfv", n_fv - base_fv, 1);

    // reset after 17 bytes
    issue(8'h73);
    tick();
    pulse_tx_done();
    for (int i = 0; i < 17; i++) send_byte(8'(i + 1));
    base_fv = n_fv;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_frame", frame_out, 0);
    chk("mid_rst_busy", busy, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(); tick();
    chk("mid_rst_nfv", n_fv - base_fv, 0);

    // new "s": early byte in WAIT_TX, then byte together with tx_done
    base_fv = n_fv;
    issue(8'h73);
    tick();
    r_exp = '0;
    for (int i = 0; i < 40; i++) r_exp[i*8 +: 8] = 8'(8'hA0 + i);
    send_byte(8'hA0);
    tx_done = 1'b1;
    send_byte(8'hA1);
    tx_done = 1'b0;
    for (int i = 2; i < 40; i++) send_byte(8'(8'hA0 + i));
    chk("re_fv", frame_valid, 1);
    chk("re_frame", frame_out, r_exp);
    tick();
    chk("re_nfv", n_fv - base_fv, 1);

`ifdef DEBUG_HOST_TIMEOUT_EN
    base_fv = n_fv;
    issue(8'h73);
    tick();
    pulse_tx_done();
    for (int i = 0; i < 5; i++) send_byte(8'(8'h11 * (i + 1)));
    repeat (99) tick();
    chk("tmo_not_yet", error, 0);
    tick();
    chk("tmo_err", error, 1);
    chk("tmo_idle", busy, 0);
    chk("tmo_partial", frame_out[39:0], 40'h55_44_33_22_11);
    tick();
    chk("tmo_nfv", n_fv - base_fv, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
